// File: rtl/salu_exec_state_pkg.sv
// Shared widths and the per-wavefront state record for the SALU exec-state block.
package salu_exec_state_pkg;

  localparam int EXEC_W = 64;
  localparam int VCC_W  = 64;
  localparam int M0_W   = 32;
  localparam int WFID_W = 6;

  typedef struct packed {
    logic [EXEC_W-1:0] exec;
    logic [VCC_W-1:0]  vcc;
    logic [M0_W-1:0]   m0;
    logic              scc;
  } wf_state_t;

endpackage

// File: rtl/salu_exec_entry.sv
// One wavefront's EXEC/VCC/M0/SCC with write merging (init > salu > valu per field).
module salu_exec_entry
  import salu_exec_state_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_en,
  input  logic [EXEC_W-1:0] init_exec,
  input  logic              salu_exec_en,
  input  logic              salu_vcc_en,
  input  logic              salu_m0_en,
  input  logic              salu_scc_en,
  input  wf_state_t         salu_wr,
  input  logic              valu_vcc_en,
  input  logic [VCC_W-1:0]  valu_vcc,
  output wf_state_t         rd_state
);

  wf_state_t state_r;
  wf_state_t state_nxt_s;

  // Per-field write merge; init clears everything except the supplied EXEC.
  always_comb begin
    state_nxt_s = state_r;
    if (init_en) begin
      state_nxt_s.exec = init_exec;
      state_nxt_s.vcc  = {VCC_W{1'b0}};
      state_nxt_s.m0   = {M0_W{1'b0}};
      state_nxt_s.scc  = 1'b0;
    end else begin
      if (salu_exec_en) state_nxt_s.exec = salu_wr.exec;
      else              state_nxt_s.exec = state_r.exec;
      if (salu_vcc_en)      state_nxt_s.vcc = salu_wr.vcc;
      else if (valu_vcc_en) state_nxt_s.vcc = valu_vcc;
      else                  state_nxt_s.vcc = state_r.vcc;
      if (salu_m0_en) state_nxt_s.m0 = salu_wr.m0;
      else            state_nxt_s.m0 = state_r.m0;
      if (salu_scc_en) state_nxt_s.scc = salu_wr.scc;
      else             state_nxt_s.scc = state_r.scc;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= '0;
    else      state_r <= state_nxt_s;
  end

  // Forwarding view exposes the merged next value so a same-edge read sees the write.
  assign rd_state = BYPASS_EN ? state_nxt_s : state_r;

endmodule

// File: rtl/salu_exec_state.sv
// Per-wavefront EXEC/VCC/M0/SCC state with a 1-cycle registered read port.
// Optional SALU_EXEC_BYPASS_EN forwards same-edge writes into the read data.
module salu_exec_state
  import salu_exec_state_pkg::*;
#(
  parameter int NUM_WF = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_en,
  input  logic [WFID_W-1:0] init_wfid,
  input  logic [EXEC_W-1:0] init_exec,
  input  logic              salu_rd_en,
  input  logic [WFID_W-1:0] salu_rd_wfid,
  output logic [EXEC_W-1:0] salu_rd_exec_value,
  output logic [VCC_W-1:0]  salu_rd_vcc_value,
  output logic [M0_W-1:0]   salu_rd_m0_value,
  output logic              salu_rd_scc_value,
  output logic              salu_rd_valid,
  output logic              salu_rd_execz,
  output logic              salu_rd_vccz,
  input  logic              salu_wr_exec_en,
  input  logic              salu_wr_vcc_en,
  input  logic              salu_wr_m0_en,
  input  logic              salu_wr_scc_en,
  input  logic [WFID_W-1:0] salu_wr_wfid,
  input  logic [EXEC_W-1:0] salu_wr_exec_value,
  input  logic [VCC_W-1:0]  salu_wr_vcc_value,
  input  logic [M0_W-1:0]   salu_wr_m0_value,
  input  logic              salu_wr_scc_value,
  input  logic              valu_wr_vcc_en,
  input  logic [WFID_W-1:0] valu_wr_vcc_wfid,
  input  logic [VCC_W-1:0]  valu_wr_vcc_value
);

`ifdef SALU_EXEC_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  wf_state_t salu_wr_s;
  wf_state_t rd_view_s [NUM_WF];
  wf_state_t rd_sel_s;

  assign salu_wr_s = '{exec: salu_wr_exec_value, vcc: salu_wr_vcc_value,
                       m0: salu_wr_m0_value, scc: salu_wr_scc_value};

  // Out-of-range wfids match no entry, so their writes fall away naturally.
  for (genvar i = 0; i < NUM_WF; i++) begin : g_entry
    logic init_hit_s;
    logic salu_hit_s;
    logic valu_hit_s;

    assign init_hit_s = init_en && (init_wfid == WFID_W'(i));
    assign salu_hit_s = (salu_wr_wfid == WFID_W'(i));
    assign valu_hit_s = valu_wr_vcc_en && (valu_wr_vcc_wfid == WFID_W'(i));

    salu_exec_entry #(.BYPASS_EN(BYPASS_EN)) u_entry (
      .clk          (clk),
      .rst          (rst),
      .init_en      (init_hit_s),
      .init_exec    (init_exec),
      .salu_exec_en (salu_wr_exec_en && salu_hit_s),
      .salu_vcc_en  (salu_wr_vcc_en && salu_hit_s),
      .salu_m0_en   (salu_wr_m0_en && salu_hit_s),
      .salu_scc_en  (salu_wr_scc_en && salu_hit_s),
      .salu_wr      (salu_wr_s),
      .valu_vcc_en  (valu_hit_s),
      .valu_vcc     (valu_wr_vcc_value),
      .rd_state     (rd_view_s[i])
    );
  end

  // AND-OR read select; a wfid with no entry yields all zeros.
  always_comb begin
    rd_sel_s = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      rd_sel_s = rd_sel_s | ((salu_rd_wfid == WFID_W'(i)) ? rd_view_s[i] : wf_state_t'('0));
    end
  end

  // Read data register; zero flags are captured with the data they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      salu_rd_exec_value <= {EXEC_W{1'b0}};
      salu_rd_vcc_value  <= {VCC_W{1'b0}};
      salu_rd_m0_value   <= {M0_W{1'b0}};
      salu_rd_scc_value  <= 1'b0;
      salu_rd_valid      <= 1'b0;
      salu_rd_execz      <= 1'b1;
      salu_rd_vccz       <= 1'b1;
    end else if (salu_rd_en) begin
      salu_rd_exec_value <= rd_sel_s.exec;
      salu_rd_vcc_value  <= rd_sel_s.vcc;
      salu_rd_m0_value   <= rd_sel_s.m0;
      salu_rd_scc_value  <= rd_sel_s.scc;
      salu_rd_valid      <= 1'b1;
      salu_rd_execz      <= (rd_sel_s.exec == {EXEC_W{1'b0}});
      salu_rd_vccz       <= (rd_sel_s.vcc == {VCC_W{1'b0}});
    end else begin
      salu_rd_valid      <= 1'b0;
    end
  end

endmodule
